alu_issue: RTL and testbench



---
 rtl/alu_pkg.sv | 22 ++
 rtl/regbank4.sv | 25 ++
 rtl/alu_issue.sv | 147 ++++++++++++++
 tb/tb_alu_issue.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM states, instruction layout and opcode constants for alu_issue.
package alu_pkg;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;
  typedef struct packed {
    logic       kind;
    logic       l;
    logic [1:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [1:0] lo;
  } instr_t;
  localparam logic KIND_ALU = 1'b0;
  localparam logic KIND_LDI = 1'b1;
  localparam logic [1:0] OP_NEGA = 2'b00;
  localparam logic [1:0] OP_NEGB = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;
  // LDI reuses the rs and ignored fields as the 4-bit immediate
  function automatic logic [3:0] ldi_imm(instr_t i);
    return {i.rs, i.lo};
  endfunction
endpackage

// File: rtl/regbank4.sv
// regbank4: small register file, one write port, two read ports plus a debug read port.
module regbank4 #(
  parameter int WIDTH = 4,
  parameter int NREG  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we_i,
  input  logic [$clog2(NREG)-1:0]   wa_i,
  input  logic [WIDTH-1:0]          wd_i,
  input  logic [$clog2(NREG)-1:0]   ra_a_i,
  input  logic [$clog2(NREG)-1:0]   ra_b_i,
  input  logic [$clog2(NREG)-1:0]   dbg_sel_i,
  output logic [WIDTH-1:0]          rd_a_o,
  output logic [WIDTH-1:0]          rd_b_o,
  output logic [WIDTH-1:0]          dbg_data_o
);
  logic [WIDTH-1:0] mem_q [NREG];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mem_q <= '{default: '0};
    else if (we_i) mem_q[wa_i] <= wd_i;
  assign rd_a_o     = mem_q[ra_a_i];
  assign rd_b_o     = mem_q[ra_b_i];
  assign dbg_data_o = mem_q[dbg_sel_i];
endmodule

// File: rtl/alu_issue.sv
// alu_issue: accepts instruction words, sequences one ALU operation or immediate load
// through IDLE/EXEC/WB, and owns the register bank and architectural flags.
module alu_issue
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREG  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       in_instr,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [1:0]       alu_op,
  output logic             alu_l,
  input  logic [WIDTH-1:0] alu_R,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_sign,
  output logic             done,
  output logic             zero_f,
  output logic             carry_f,
  output logic             sign_f,
  input  logic [1:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);
  state_t           state_q, state_d;
  instr_t           ins;
  logic             kind_q, kind_d;
  logic [1:0]       rd_q, rd_d;
  logic [3:0]       imm_q, imm_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]       op_q, op_d;
  logic             l_q, l_d;
  logic             hz_q, hz_d, hc_q, hc_d, hs_q, hs_d;
  logic             zf_q, zf_d, cf_q, cf_d, sf_q, sf_d;
  logic [WIDTH-1:0] rd_a, rd_b;

  regbank4 #(.WIDTH(WIDTH), .NREG(NREG)) u_regs (
    .clk        (clk),
    .rst_n      (reset),
    .we_i       (state_q == S_WB),
    .wa_i       (rd_q),
    .wd_i       (kind_q == KIND_LDI ? WIDTH'(imm_q) : res_q),
    .ra_a_i     (ins.rd),
    .ra_b_i     (ins.rs),
    .dbg_sel_i  (dbg_sel),
    .rd_a_o     (rd_a),
    .rd_b_o     (rd_b),
    .dbg_data_o (dbg_data)
  );

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= S_IDLE;
      kind_q  <= 1'b0;
      rd_q    <= '0;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      l_q     <= 1'b0;
      res_q   <= '0;
      hz_q    <= 1'b0;
      hc_q    <= 1'b0;
      hs_q    <= 1'b0;
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
      sf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      l_q     <= l_d;
      res_q   <= res_d;
      hz_q    <= hz_d;
      hc_q    <= hc_d;
      hs_q    <= hs_d;
      zf_q    <= zf_d;
      cf_q    <= cf_d;
      sf_q    <= sf_d;
    end

  // ALU operands are registered at acceptance so they hold steady outside EXEC
  always_comb begin
    ins     = instr_t'(in_instr);
    state_d = state_q;
    kind_d  = kind_q;
    rd_d    = rd_q;
    imm_d   = imm_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    l_d     = l_q;
    res_d   = res_q;
    hz_d    = hz_q;
    hc_d    = hc_q;
    hs_d    = hs_q;
    zf_d    = zf_q;
    cf_d    = cf_q;
    sf_d    = sf_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        kind_d  = ins.kind;
        rd_d    = ins.rd;
        imm_d   = ldi_imm(ins);
        state_d = ins.kind == KIND_LDI ? S_WB : S_EXEC;
        if (ins.kind == KIND_ALU) begin
          a_d  = rd_a;
          b_d  = rd_b;
          op_d = ins.op;
          l_d  = ins.l;
        end
      end
      S_EXEC: begin
        res_d   = alu_R;
        hz_d    = alu_zero;
        hc_d    = alu_carry;
        hs_d    = alu_sign;
        state_d = S_WB;
      end
      S_WB: begin
        zf_d    = kind_q == KIND_LDI ? imm_q == 4'd0 : hz_q;
        sf_d    = kind_q == KIND_LDI ? imm_q[3] : hs_q;
        cf_d    = (kind_q == KIND_ALU && !l_q) ? hc_q : cf_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready = state_q == S_IDLE;
  assign done     = state_q == S_WB;
  assign alu_A    = a_q;
  assign alu_B    = b_q;
  assign alu_op   = op_q;
  assign alu_l    = l_q;
  assign zero_f   = zf_q;
  assign carry_f  = cf_q;
  assign sign_f   = sf_q;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: random and directed instruction streams against a register/flag reference model with a queue scoreboard.
module tb_alu_issue;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_instr;
  logic [3:0] alu_A, alu_B, alu_R;
  logic [1:0] alu_op;
  logic       alu_l, alu_zero, alu_carry, alu_sign;
  logic       done, zero_f, carry_f, sign_f;
  logic [1:0] dbg_sel = 2'd0;
  logic [3:0] dbg_data;
  logic       rnd_c = 1'b0;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;

  typedef struct {
    logic [1:0] rd;
    logic [3:0] val;
    bit         z, c, s;
    int         lat, acc;
    bit         is_alu;
    logic [3:0] a, b;
    logic [1:0] op;
    bit         l;
  } exp_t;
  exp_t q[$];
  logic [3:0] mreg [4];
  bit         mz, mc, ms;

  alu_issue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_l(alu_l), .alu_R(alu_R),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_sign(alu_sign), .done(done),
    .zero_f(zero_f), .carry_f(carry_f), .sign_f(sign_f), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) rnd_c <= 1'($urandom);

  // stand-in 4-bit ALU; logic-mode carry is random noise the DUT must ignore
  function automatic logic [4:0] alu_fn(input int a, input int b, input logic [1:0] op, input logic l, input logic lc);
    int r;
    logic c;
    if (l) begin
      case (op)
        2'd0: r = a & b;
        2'd1: r = a | b;
        2'd2: r = a ^ b;
        default: r = ~a;
      endcase
      r = r & 15;
      c = lc;
    end else begin
      case (op)
        OP_NEGA: begin r = (16 - a) % 16; c = (a == 0); end
        OP_NEGB: begin r = (16 - b) % 16; c = (b == 0); end
        OP_ADD:  begin r = (a + b) % 16;  c = (a + b) > 15; end
        default: begin r = (a - b + 16) % 16; c = (a >= b); end
      endcase
    end
    return {c, 4'(r)};
  endfunction

  assign {alu_carry, alu_R} = alu_fn(int'(alu_A), int'(alu_B), alu_op, alu_l, rnd_c);
  assign alu_zero = alu_R == 4'd0;
  assign alu_sign = alu_R[3];

  function automatic logic [9:0] aop(input logic l, input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs);
    return {1'b0, l, op, rd, rs, 2'b00};
  endfunction

  function automatic logic [9:0] ldi(input logic [1:0] rd, input logic [3:0] imm);
    return {1'b1, 3'b000, rd, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_push(input logic [9:0] ins, input int acc);
    exp_t e;
    logic [4:0] r;
    logic [3:0] v;
    e.rd = ins[5:4];
    e.acc = acc;
    if (ins[9]) begin
      v = ins[3:0];
      e.lat = 0;
      e.is_alu = 0;
    end else begin
      e.a = mreg[ins[5:4]];
      e.b = mreg[ins[3:2]];
      e.op = ins[7:6];
      e.l = ins[8];
      r = alu_fn(int'(e.a), int'(e.b), e.op, e.l, mc);
      v = r[3:0];
      if (!e.l) mc = r[4];
      e.lat = 1;
      e.is_alu = 1;
    end
    mz = v == 4'd0;
    ms = v[3];
    mreg[e.rd] = v;
    e.val = v;
    e.z = mz;
    e.c = mc;
    e.s = ms;
    q.push_back(e);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mreg[i] = 4'd0;
    {mz, mc, ms} = 3'b000;
  endtask

  // not-ready cycles carry junk with in_valid high; capturing it would corrupt results
  task automatic issue(input logic [9:0] ins);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 10) begin
      in_valid = 1'b1;
      in_instr = 10'($urandom);
      n++;
      @(negedge clk);
    end
    check("ready_wait", 32'(in_ready), 32'd1);
    in_instr = ins;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    model_push(ins, cyc);
    in_valid = 1'b0;
    in_instr = 10'($urandom);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = q.pop_front();
          check("latency", 32'(cyc - e.acc), 32'(e.lat));
          check("ready_in_wb", 32'(in_ready), 32'd0);
          if (e.is_alu) begin
            check("alu_A", 32'(alu_A), 32'(e.a));
            check("alu_B", 32'(alu_B), 32'(e.b));
            check("alu_op", 32'(alu_op), 32'(e.op));
            check("alu_l", 32'(alu_l), 32'(e.l));
          end
          @(negedge clk);
          dbg_sel = e.rd;
          #1;
          check("done_pulse", 32'(done), 32'd0);
          check("reg", 32'(dbg_data), 32'(e.val));
          check("zero_f", 32'(zero_f), 32'(e.z));
          check("carry_f", 32'(carry_f), 32'(e.c));
          check("sign_f", 32'(sign_f), 32'(e.s));
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_flags", 32'({zero_f, carry_f, sign_f}), 32'd0);
    check("rst_aluA", 32'(alu_A), 32'd0);
    check("rst_aluB", 32'(alu_B), 32'd0);
    reset = 1'b1;
    issue(ldi(2'd0, 4'd5));
    issue(ldi(2'd1, 4'd3));
    issue(aop(1'b0, OP_SUB, 2'd0, 2'd1));
    issue(aop(1'b0, OP_ADD, 2'd1, 2'd1));
    issue(ldi(2'd0, 4'd10));
    issue(aop(1'b0, OP_ADD, 2'd0, 2'd1));
    issue(aop(1'b1, 2'd0, 2'd0, 2'd1));
    issue(aop(1'b0, OP_SUB, 2'd2, 2'd2));
    repeat (150) begin
      if ($urandom_range(3) == 0) idle($urandom_range(3));
      issue(10'($urandom));
    end
    drain();
    issue(ldi(2'd2, 4'd9));
    issue(aop(1'b0, OP_SUB, 2'd2, 2'd3));
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    model_clear();
    #1;
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_flags", 32'({zero_f, carry_f, sign_f}), 32'd0);
    check("midrst_aluA", 32'(alu_A), 32'd0);
    check("midrst_aluB", 32'(alu_B), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int r = 0; r < 4; r++) issue(aop(1'b1, 2'd1, 2'(r), 2'(r)));
    repeat (100) begin
      if ($urandom_range(3) == 0) idle($urandom_range(3));
      issue(10'($urandom));
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
    $fatal(1);
  end
endmodule
